// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serializer / detector pair.
//  - state_e   : serializer FSM encoding
//  - DEF_WIDTH : default word width, also used by the detector's test vectors
//  - len_w()   : width of a bit-count field able to hold 0..w
package pattern_pkg;

    localparam int unsigned DEF_WIDTH = 10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int unsigned len_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Remaining-bit counter for the serializer.
// Ports:
//  clock, reset_n : rising-edge clock, async active-low reset
//  enable         : 0 holds the count
//  load, value    : load a new count (takes priority over dec)
//  dec            : decrement by one (saturates at 0)
//  cnt            : current count
//  is_one         : cnt == 1, i.e. the final bit of a word is on the line
module bit_down_counter #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [LEN_W-1:0] value,
    input  logic             dec,
    output logic [LEN_W-1:0] cnt,
    output logic             is_one
);

    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (load) begin
                r_cnt <= value;
            end else if (dec && (r_cnt != '0)) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end

    assign cnt    = r_cnt;
    assign is_one = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial stage feeding the Mealy pattern detector.
// A word of up to WIDTH bits is accepted over valid/ready and shifted out one bit per
// enabled clock. A new word can be accepted on the cycle the last bit is shown, so
// consecutive words stream with no idle gap.
// Ports:
//  clock, reset_n    : rising-edge clock, async active-low reset
//  enable            : 1 advance/accept, 0 hold everything
//  in_valid/in_ready : word handshake (in_ready is combinational)
//  in_data, in_len   : word and bit count L (clamped to WIDTH; 0 = drop the word)
//  bit_out           : serial bit (IDLE_LEVEL when no bit is valid)
//  bit_valid         : bit_out carries a word bit
//  bit_last          : bit_out is the final bit of its word
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0,
    localparam int unsigned LEN_W     = len_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_bit_last;

    logic [LEN_W-1:0] w_len;
    logic [LEN_W-1:0] w_cnt;
    logic             w_is_one;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_aligned;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_first_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_next_rest;

    // ------------------------------------------------------------------ datapath helpers
    always_comb begin
        w_len    = (in_len > WIDTH_L) ? WIDTH_L : in_len;
        w_accept = in_valid & in_ready;
        // A zero-length word completes the handshake but loads nothing.
        w_load   = w_accept & (w_len != '0);
        // Keep only the low L bits so the shift register never holds stale upper bits.
        w_mask   = ~({WIDTH{1'b1}} << w_len);
        w_masked = in_data & w_mask;
    end

    // MSB-first left-aligns the word so both first and subsequent bits come from the top.
    always_comb begin
        w_aligned = '0;
        if (MSB_FIRST) begin
            w_aligned    = w_masked << (WIDTH_L - w_len);
            w_first_bit  = w_aligned[WIDTH-1];
            w_first_rest = w_aligned << 1;
            w_next_bit   = r_shreg[WIDTH-1];
            w_next_rest  = r_shreg << 1;
        end else begin
            w_first_bit  = w_masked[0];
            w_first_rest = w_masked >> 1;
            w_next_bit   = r_shreg[0];
            w_next_rest  = r_shreg >> 1;
        end
    end

    bit_down_counter #(
        .LEN_W (LEN_W)
    ) u_bit_down_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .load    (w_load),
        .value   (w_len),
        .dec     (r_state == ST_SHIFT),
        .cnt     (w_cnt),
        .is_one  (w_is_one)
    );

    // ------------------------------------------------------------------ FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------ FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (enable && w_is_one) begin
                    w_state_next = w_load ? ST_SHIFT : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ FSM: outputs
    always_comb begin
        in_ready = enable & ((r_state == ST_IDLE) | ((r_state == ST_SHIFT) & w_is_one));
    end

    // ------------------------------------------------------------------ shift/output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg     <= '0;
            r_bit_out   <= IDLE_LEVEL;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
        end else if (enable) begin
            if (w_load) begin
                r_shreg     <= w_first_rest;
                r_bit_out   <= w_first_bit;
                r_bit_valid <= 1'b1;
                r_bit_last  <= (w_len == LEN_W'(1));
            end else if (r_state == ST_SHIFT && !w_is_one) begin
                r_shreg     <= w_next_rest;
                r_bit_out   <= w_next_bit;
                r_bit_last  <= (w_cnt == LEN_W'(2));
            end else if (r_state == ST_SHIFT) begin
                r_bit_out   <= IDLE_LEVEL;
                r_bit_valid <= 1'b0;
                r_bit_last  <= 1'b0;
            end
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_last  = r_bit_last;

endmodule
